// File: rtl/gmii_rx_frame_adapter.sv
// GMII receive framer: nibble/byte assembly, preamble/SFD strip,
// one-byte lookahead for last-byte marking, and in-band status decode.
module gmii_rx_frame_adapter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic [1:0] speed,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_last,
    output logic       rx_bad,
    output logic       bad_preamble,
    output logic       false_carrier,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex
);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] spd_q, spd_d;
    logic       nib_have_q, nib_have_d;
    logic [3:0] nib_lo_q, nib_lo_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_v_q, hold_v_d;
    logic       first_q, first_d;
    logic       err_q, err_d;

    logic [7:0] data_d;
    logic       valid_d, sof_d, last_d, bad_d;
    logic       bad_pre_d, fc_d;
    logic       link_up_d, full_duplex_d;
    logic [1:0] link_speed_d;

    logic       nib_mode;
    logic       pre_eval;
    logic       pre_ok;
    logic       pre_sfd;
    logic       byte_done;
    logic [7:0] byte_val;

    // Speed is taken live on the first unit of a frame, latched after.
    assign nib_mode = (state_q == IDLE) ? (speed < 2'd2)
                                        : (spd_q < 2'd2);

    // A nibble SFD only counts once at least one 0x5 has been seen.
    assign pre_ok  = nib_mode ? (gmii_rxd[3:0] == 4'h5)
                              : (gmii_rxd == 8'h55);
    assign pre_sfd = nib_mode ? (gmii_rxd[3:0] == 4'hD &&
                                 state_q == PREAMBLE)
                              : (gmii_rxd == 8'hD5);

    always_comb begin
        state_d       = state_q;
        spd_d         = spd_q;
        nib_have_d    = nib_have_q;
        nib_lo_d      = nib_lo_q;
        hold_d        = hold_q;
        hold_v_d      = hold_v_q;
        first_d       = first_q;
        err_d         = err_q;
        data_d        = rx_data;
        valid_d       = 1'b0;
        sof_d         = 1'b0;
        last_d        = 1'b0;
        bad_d         = 1'b0;
        bad_pre_d     = 1'b0;
        fc_d          = 1'b0;
        link_up_d     = link_up;
        link_speed_d  = link_speed;
        full_duplex_d = full_duplex;
        pre_eval      = 1'b0;
        byte_done     = 1'b0;
        byte_val      = gmii_rxd;

        unique case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    spd_d    = speed;
                    pre_eval = 1'b1;
                end else if (!gmii_rx_er) begin
                    link_up_d     = gmii_rxd[0];
                    link_speed_d  = gmii_rxd[2:1];
                    full_duplex_d = gmii_rxd[3];
                end else if (gmii_rxd == 8'h0E) begin
                    fc_d = 1'b1;
                end
            end
            PREAMBLE: begin
                if (gmii_rx_dv) pre_eval = 1'b1;
                else            state_d  = IDLE;
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    if (gmii_rx_er) err_d = 1'b1;
                    if (!nib_mode) begin
                        byte_done = 1'b1;
                    end else if (!nib_have_q) begin
                        nib_lo_d   = gmii_rxd[3:0];
                        nib_have_d = 1'b1;
                    end else begin
                        byte_done  = 1'b1;
                        byte_val   = {gmii_rxd[3:0], nib_lo_q};
                        nib_have_d = 1'b0;
                    end
                    if (byte_done) begin
                        if (hold_v_q) begin
                            valid_d = 1'b1;
                            data_d  = hold_q;
                            sof_d   = first_q;
                            first_d = 1'b0;
                        end
                        hold_d   = byte_val;
                        hold_v_d = 1'b1;
                    end
                end else begin
                    if (hold_v_q) begin
                        valid_d = 1'b1;
                        data_d  = hold_q;
                        sof_d   = first_q;
                        last_d  = 1'b1;
                        bad_d   = err_q | nib_have_q;
                    end else begin
                        bad_pre_d = 1'b1;
                    end
                    hold_v_d   = 1'b0;
                    nib_have_d = 1'b0;
                    err_d      = 1'b0;
                    first_d    = 1'b0;
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pre_eval) begin
            if (pre_sfd) begin
                state_d    = DATA;
                first_d    = 1'b1;
                err_d      = 1'b0;
                nib_have_d = 1'b0;
                hold_v_d   = 1'b0;
            end else if (pre_ok) begin
                state_d = PREAMBLE;
            end else begin
                bad_pre_d = 1'b1;
                state_d   = DROP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            spd_q         <= 2'b00;
            nib_have_q    <= 1'b0;
            nib_lo_q      <= 4'h0;
            hold_q        <= 8'h00;
            hold_v_q      <= 1'b0;
            first_q       <= 1'b0;
            err_q         <= 1'b0;
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            rx_sof        <= 1'b0;
            rx_last       <= 1'b0;
            rx_bad        <= 1'b0;
            bad_preamble  <= 1'b0;
            false_carrier <= 1'b0;
            link_up       <= 1'b0;
            link_speed    <= 2'b00;
            full_duplex   <= 1'b0;
        end else begin
            state_q       <= state_d;
            spd_q         <= spd_d;
            nib_have_q    <= nib_have_d;
            nib_lo_q      <= nib_lo_d;
            hold_q        <= hold_d;
            hold_v_q      <= hold_v_d;
            first_q       <= first_d;
            err_q         <= err_d;
            rx_data       <= data_d;
            rx_valid      <= valid_d;
            rx_sof        <= sof_d;
            rx_last       <= last_d;
            rx_bad        <= bad_d;
            bad_preamble  <= bad_pre_d;
            false_carrier <= fc_d;
            link_up       <= link_up_d;
            link_speed    <= link_speed_d;
            full_duplex   <= full_duplex_d;
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_adapter.sv
// Directed bench for gmii_rx_frame_adapter: framing, latency,
// preamble errors, in-band status and reset behaviour.
module tb_gmii_rx_frame_adapter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic [1:0] speed;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sof, rx_last, rx_bad;
    logic       bad_preamble, false_carrier;
    logic       link_up, full_duplex;
    logic [1:0] link_speed;

    gmii_rx_frame_adapter dut (
        .clk           (clk),
        .rst           (rst),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
        .speed         (speed),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_last       (rx_last),
        .rx_bad        (rx_bad),
        .bad_preamble  (bad_preamble),
        .false_carrier (false_carrier),
        .link_up       (link_up),
        .link_speed    (link_speed),
        .full_duplex   (full_duplex)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       last;
        logic       bad;
        int         c;
    } beat_t;

    beat_t q[$];
    int cyc     = 0;
    int n_bp    = 0;
    int n_fc    = 0;
    int n_stray = 0;
    int checks  = 0;
    int passes  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid)
            q.push_back('{rx_data, rx_sof, rx_last, rx_bad, cyc});
        if (bad_preamble)  n_bp <= n_bp + 1;
        if (false_carrier) n_fc <= n_fc + 1;
        if (!rx_valid && (rx_sof || rx_last || rx_bad))
            n_stray <= n_stray + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input logic [7:0] d, input logic v,
                        input logic e);
        gmii_rxd   = d;
        gmii_rx_dv = v;
        gmii_rx_er = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'h0D, 1'b0, 1'b0);
    endtask

    task automatic gig_pre();
        repeat (7) step(8'h55, 1'b1, 1'b0);
        step(8'hD5, 1'b1, 1'b0);
    endtask

    task automatic nib_frame(input int npre, input bit odd);
        int t_hi, t_end;
        q.delete();
        speed = 2'b01;
        repeat (npre) step(8'h05, 1'b1, 1'b0);
        step(8'h0D, 1'b1, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h02, 1'b1, 1'b0);
        t_hi = cyc;
        step(8'h00, 1'b1, 1'b0);
        if (odd) step(8'h03, 1'b1, 1'b0);
        t_end = cyc;
        idle(4);
        chk("nib_cnt", q.size(), 2);
        if (q.size() == 2) begin
            chk("nib_d0", q[0].d, 8'h01);
            chk("nib_sof0", q[0].sof, 1);
            chk("nib_last0", q[0].last, 0);
            chk("nib_lat0", q[0].c, t_hi + 1);
            chk("nib_d1", q[1].d, 8'h02);
            chk("nib_sof1", q[1].sof, 0);
            chk("nib_last1", q[1].last, 1);
            chk("nib_bad1", q[1].bad, odd);
            chk("nib_lat1", q[1].c, t_end + 1);
        end
    endtask

    initial begin
        int t0[64];
        int b0, f0, nbad;

        rst = 1'b1;
        speed = 2'b10;
        gmii_rxd = 8'h00;
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        repeat (3) step(8'h00, 1'b0, 1'b0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_link", link_up, 0);
        chk("rst_lspd", link_speed, 2'b00);
        chk("rst_fdx", full_duplex, 0);
        chk("rst_bp", bad_preamble, 0);
        chk("rst_fc", false_carrier, 0);
        rst = 1'b0;

        // in-band status 0x0D: link up, 1000M, full duplex
        step(8'h0D, 1'b0, 1'b0);
        chk("st_link", link_up, 1);
        chk("st_lspd", link_speed, 2'b10);
        chk("st_fdx", full_duplex, 1);

        f0 = n_fc;
        step(8'h0E, 1'b0, 1'b1);
        chk("fc_pulse", false_carrier, 1);
        chk("fc_link_hold", link_up, 1);
        step(8'h0D, 1'b0, 1'b0);
        chk("fc_end", false_carrier, 0);
        chk("fc_cnt", n_fc - f0, 1);

        // 1000M, 64-byte payload
        q.delete();
        speed = 2'b10;
        gig_pre();
        for (int i = 0; i < 64; i++) begin
            t0[i] = cyc;
            step(8'(i + 1), 1'b1, 1'b0);
        end
        idle(4);
        chk("g_cnt", q.size(), 64);
        for (int i = 0; i < 64 && i < q.size(); i++) begin
            chk("g_data", q[i].d, 32'(i + 1));
            chk("g_lat", q[i].c - t0[i], 2);
            chk("g_sof", q[i].sof, (i == 0));
            chk("g_last", q[i].last, (i == 63));
            chk("g_bad", q[i].bad, 0);
        end

        // 100M, odd and even preambles, then dangling nibble
        nib_frame(15, 1'b0);
        nib_frame(14, 1'b0);
        nib_frame(15, 1'b1);

        // 1000M bad preamble, then a good frame
        speed = 2'b10;
        q.delete();
        b0 = n_bp;
        step(8'h55, 1'b1, 1'b0);
        step(8'h54, 1'b1, 1'b0);
        chk("bp_pulse", bad_preamble, 1);
        step(8'h33, 1'b1, 1'b0);
        chk("bp_single", bad_preamble, 0);
        step(8'h33, 1'b1, 1'b0);
        idle(2);
        chk("bp_cnt", n_bp - b0, 1);
        chk("bp_nobeat", q.size(), 0);
        gig_pre();
        step(8'hA1, 1'b1, 1'b0);
        step(8'hA2, 1'b1, 1'b0);
        step(8'hA3, 1'b1, 1'b0);
        idle(3);
        chk("bp_next_cnt", q.size(), 3);
        if (q.size() == 3) begin
            chk("bp_next_d0", q[0].d, 8'hA1);
            chk("bp_next_sof", q[0].sof, 1);
            chk("bp_next_d2", q[2].d, 8'hA3);
            chk("bp_next_last", q[2].last, 1);
            chk("bp_next_bad", q[2].bad, 0);
        end

        // 1000M error mid-payload
        q.delete();
        gig_pre();
        for (int i = 0; i < 10; i++)
            step(8'(8'h10 + i), 1'b1, (i == 4));
        idle(3);
        chk("er_cnt", q.size(), 10);
        nbad = 0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].bad) nbad++;
        chk("er_nbad", nbad, 1);
        if (q.size() == 10) begin
            chk("er_lastbad", q[9].bad, 1);
            chk("er_last", q[9].last, 1);
            chk("er_d9", q[9].d, 8'h19);
        end

        // reset mid-DATA, dv still high on release
        gig_pre();
        step(8'hC1, 1'b1, 1'b0);
        step(8'hC2, 1'b1, 1'b0);
        step(8'hC3, 1'b1, 1'b0);
        chk("pre_rst_valid", rx_valid, 1);
        rst = 1'b1;
        step(8'hC4, 1'b1, 1'b0);
        chk("mr_valid", rx_valid, 0);
        chk("mr_data", rx_data, 8'h00);
        chk("mr_last", rx_last, 0);
        chk("mr_sof", rx_sof, 0);
        chk("mr_bad", rx_bad, 0);
        chk("mr_link", link_up, 0);
        chk("mr_lspd", link_speed, 2'b00);
        chk("mr_fdx", full_duplex, 0);
        q.delete();
        b0 = n_bp;
        rst = 1'b0;
        step(8'hC5, 1'b1, 1'b0);
        chk("mr_rel_bp", bad_preamble, 1);
        step(8'hC6, 1'b1, 1'b0);
        idle(3);
        chk("mr_bp_cnt", n_bp - b0, 1);
        chk("mr_nobeat", q.size(), 0);
        chk("stray_flags", n_stray, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
